knn_mem_master: RTL and testbench



---
 rtl/knn_mem_master.sv | 191 +++++++++++++++++++
 tb/tb_knn_mem_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/knn_mem_master.sv
// Bus-master engine: reads packed points, keeps the K nearest point indices sorted by squared
// distance to a test point, then writes those indices back to memory.
module knn_mem_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned K      = 4,
  parameter int unsigned IDX_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [IDX_W-1:0]    n_points_i,
  input  logic [DATA_W-1:0]   test_point_i,
  input  logic [ADDR_W-1:0]   result_addr_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                m_valid_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_ready_i
);
  localparam int unsigned JW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned DW = 34;

  typedef enum logic [2:0] {StIdle, StRead, StCalc, StWrite, StWGap, StDone} state_e;
  state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d, res_q, res_d;
  logic [IDX_W-1:0]  n_q, n_d, i_q, i_d;
  logic [DATA_W-1:0] test_q, test_d, point_q, point_d;
  logic [JW-1:0]     j_q, j_d;
  logic [DW-1:0]     dist_q [K];
  logic [DW-1:0]     dist_d [K];
  logic [IDX_W-1:0]  idx_q [K];
  logic [IDX_W-1:0]  idx_d [K];

  // Exact squared distance: 17-bit differences, 34-bit sum never overflows.
  logic signed [16:0]   dx, dy;
  logic signed [DW-1:0] dx_w, dy_w, sq_x, sq_y;
  logic [DW-1:0]        new_dist;

  always_comb begin
    dx = $signed({point_q[31], point_q[31:16]}) - $signed({test_q[31], test_q[31:16]});
    dy = $signed({point_q[15], point_q[15:0]}) - $signed({test_q[15], test_q[15:0]});
    dx_w = {{(DW-17){dx[16]}}, dx};
    dy_w = {{(DW-17){dy[16]}}, dy};
    sq_x = dx_w * dx_w;
    sq_y = dy_w * dy_w;
    new_dist = $unsigned(sq_x) + $unsigned(sq_y);
  end

  // New entry lands after every entry with dist <= new_dist, so ties keep the earlier index.
  logic [DW-1:0]    ins_dist [K];
  logic [IDX_W-1:0] ins_idx [K];
  logic             accept, prev_le, cur_le;

  always_comb begin
    accept  = new_dist < dist_q[K-1];
    prev_le = 1'b1;
    cur_le  = 1'b0;
    for (int k = 0; k < K; k++) begin
      ins_dist[k] = dist_q[k];
      ins_idx[k]  = idx_q[k];
      cur_le      = dist_q[k] <= new_dist;
      if (!cur_le) begin
        if (prev_le) begin
          ins_dist[k] = new_dist;
          ins_idx[k]  = i_q;
        end else begin
          ins_dist[k] = dist_q[(k == 0) ? 0 : k - 1];
          ins_idx[k]  = idx_q[(k == 0) ? 0 : k - 1];
        end
      end
      prev_le = cur_le;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    res_d   = res_q;
    n_d     = n_q;
    i_d     = i_q;
    test_d  = test_q;
    point_d = point_q;
    j_d     = j_q;
    dist_d  = dist_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d  = base_addr_i;
          res_d   = result_addr_i;
          n_d     = n_points_i;
          test_d  = test_point_i;
          i_d     = '0;
          j_d     = '0;
          for (int k = 0; k < K; k++) begin
            dist_d[k] = '1;
            idx_d[k]  = '1;
          end
          state_d = (n_points_i != '0) ? StRead : StWrite;
        end
      end
      StRead: begin
        if (m_ready_i) begin
          point_d = m_rdata_i;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (accept) begin
          dist_d = ins_dist;
          idx_d  = ins_idx;
        end
        if (i_q + IDX_W'(1) < n_q) begin
          i_d     = i_q + IDX_W'(1);
          state_d = StRead;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (m_ready_i) begin
          if (j_q == JW'(K - 1)) begin
            state_d = StDone;
          end else begin
            j_d     = j_q + JW'(1);
            state_d = StWGap;
          end
        end
      end
      StWGap:  state_d = StWrite;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs depend only on registered state, so they hold steady through wait cycles.
  always_comb begin
    m_valid_o = 1'b0;
    m_addr_o  = '0;
    m_wdata_o = '0;
    m_wstrb_o = '0;
    busy_o    = state_q inside {StRead, StCalc, StWrite, StWGap};
    done_o    = state_q == StDone;
    if (state_q == StRead) begin
      m_valid_o = 1'b1;
      m_addr_o  = base_q + (ADDR_W'(i_q) << 2);
    end else if (state_q == StWrite) begin
      m_valid_o = 1'b1;
      m_addr_o  = res_q + (ADDR_W'(j_q) << 2);
      m_wstrb_o = '1;
      m_wdata_o = (idx_q[j_q] == '1) ? '1 : DATA_W'(idx_q[j_q]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      base_q  <= '0;
      res_q   <= '0;
      n_q     <= '0;
      i_q     <= '0;
      test_q  <= '0;
      point_q <= '0;
      j_q     <= '0;
      for (int k = 0; k < K; k++) begin
        dist_q[k] <= '1;
        idx_q[k]  <= '1;
      end
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      res_q   <= res_d;
      n_q     <= n_d;
      i_q     <= i_d;
      test_q  <= test_d;
      point_q <= point_d;
      j_q     <= j_d;
      for (int k = 0; k < K; k++) begin
        dist_q[k] <= dist_d[k];
        idx_q[k]  <= idx_d[k];
      end
    end
  end

endmodule

// File: tb/tb_knn_mem_master.sv
// Table-driven bench for knn_mem_master with a latency-programmable memory model that also
// watches request stability and the idle cycle between requests.
module tb_knn_mem_master;
  logic        clk_i = 1'b0;
  logic        rst_i, start_i;
  logic [31:0] base_addr_i, test_point_i, result_addr_i;
  logic [15:0] n_points_i;
  logic        busy_o, done_o, m_valid_o;
  logic [31:0] m_addr_o, m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic [31:0] m_rdata_i;
  logic        m_ready_i;

  always #5 clk_i = ~clk_i;

  knn_mem_master dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .n_points_i(n_points_i), .test_point_i(test_point_i), .result_addr_i(result_addr_i),
    .busy_o(busy_o), .done_o(done_o), .m_valid_o(m_valid_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_rdata_i(m_rdata_i), .m_ready_i(m_ready_i)
  );

  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0]      base;
    logic [31:0]      res;
    logic [31:0]      tp;
    logic [7:0]       n;
    logic [7:0]       lat;
    logic [4:0][31:0] pts;
    logic [3:0][31:0] exp;
  } vec_t;

  int n_cmp = 0, n_fail = 0;
  int hold_err = 0;
  int mem_lat = 0;
  logic [31:0] mem_base = '0;
  logic [31:0] mem_pts [8];
  logic [31:0] rd_addr [$];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic [3:0]  wr_strb [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int x, input int y);
    pk = {x[15:0], y[15:0]};
  endfunction

  function automatic vec_t mk(input logic [31:0] base, res, tp, input int n, lat,
                              input logic [31:0] p0, p1, p2, p3, p4, e0, e1, e2, e3);
    vec_t v;
    v.base = base; v.res = res; v.tp = tp; v.n = 8'(n); v.lat = 8'(lat);
    v.pts[0] = p0; v.pts[1] = p1; v.pts[2] = p2; v.pts[3] = p3; v.pts[4] = p4;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  // Memory model: sampled 1 time unit after each rising edge; ready answers after mem_lat waits.
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [67:0] prev_bus = '0;
  int unsigned wcnt = 0;
  logic [31:0] off;
  always begin
    @(posedge clk_i);
    #1;
    if (m_valid_o && prev_valid) begin
      if (prev_ready) hold_err++;
      else if ({m_addr_o, m_wdata_o, m_wstrb_o} !== prev_bus) hold_err++;
    end
    prev_valid = m_valid_o;
    prev_bus   = {m_addr_o, m_wdata_o, m_wstrb_o};
    if (m_valid_o && wcnt >= mem_lat) begin
      m_ready_i = 1'b1;
      wcnt      = 0;
      if (m_wstrb_o == 4'h0) begin
        rd_addr.push_back(m_addr_o);
        off       = (m_addr_o - mem_base) >> 2;
        m_rdata_i = (off < 8) ? mem_pts[off[2:0]] : 32'h0;
      end else begin
        wr_addr.push_back(m_addr_o);
        wr_data.push_back(m_wdata_o);
        wr_strb.push_back(m_wstrb_o);
      end
    end else begin
      m_ready_i = 1'b0;
      m_rdata_i = 32'hDEAD_BEEF;
      wcnt      = m_valid_o ? wcnt + 1 : 0;
    end
    prev_ready = m_ready_i;
  end

  // poke=1: junk start while busy; poke=2: start in the done cycle.
  task automatic run(input vec_t v, input int poke, output int dones);
    int cyc;
    mem_base = v.base;
    mem_lat  = int'(v.lat);
    for (int i = 0; i < 5; i++) mem_pts[i] = v.pts[i];
    rd_addr.delete(); wr_addr.delete(); wr_data.delete(); wr_strb.delete();
    hold_err      = 0;
    base_addr_i   = v.base;
    n_points_i    = 16'(v.n);
    test_point_i  = v.tp;
    result_addr_i = v.res;
    start_i       = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    dones   = 0;
    cyc     = 0;
    while (dones == 0 && cyc < 3000) begin
      if (poke == 1 && cyc == 4) begin
        start_i = 1'b1; base_addr_i = 32'h5000; n_points_i = 16'd1;
        test_point_i = 32'h1234_5678; result_addr_i = 32'h9000;
      end
      @(posedge clk_i); #1;
      start_i = 1'b0;
      cyc++;
      if (done_o) dones++;
    end
    if (poke == 2) start_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (done_o) dones++;
    end
  endtask

  task automatic check_run(input vec_t v, input int dones);
    logic [31:0] ea;
    check("done_pulses", 64'(dones), 64'd1);
    check("read_count", 64'(rd_addr.size()), 64'(v.n));
    for (int i = 0; i < rd_addr.size() && i < int'(v.n); i++) begin
      ea = v.base + 32'(4 * i);
      check("read_addr", rd_addr[i], ea);
    end
    check("write_count", 64'(wr_addr.size()), 64'd4);
    for (int j = 0; j < 4 && j < wr_addr.size(); j++) begin
      ea = v.res + 32'(4 * j);
      check("write_addr", wr_addr[j], ea);
      check("write_data", wr_data[j], v.exp[j]);
      check("write_strb", 64'(wr_strb[j]), 64'hF);
    end
    check("hold_and_gap", 64'(hold_err), 64'd0);
    check("busy_after", 64'(busy_o), 64'd0);
  endtask

  vec_t vecs [8];
  int   dones, cyc;

  initial begin
    for (int i = 0; i < 8; i++) mem_pts[i] = '0;
    m_ready_i = 1'b0; m_rdata_i = '0; start_i = 1'b0; rst_i = 1'b1;
    base_addr_i = '0; n_points_i = '0; test_point_i = '0; result_addr_i = '0;

    vecs[0] = mk(32'h1000, 32'h100, pk(0, 0), 5, 0, pk(3, 4), pk(1, 1), pk(-2, 0), pk(10, 10),
                 pk(0, 1), 32'd4, 32'd1, 32'd2, 32'd0);
    vecs[1] = mk(32'h1000, 32'h100, pk(0, 0), 5, 3, pk(3, 4), pk(1, 1), pk(-2, 0), pk(10, 10),
                 pk(0, 1), 32'd4, 32'd1, 32'd2, 32'd0);
    vecs[2] = mk(32'h2000, 32'h200, pk(0, 0), 5, 1, pk(1, 0), pk(0, 1), pk(-1, 0), pk(0, -1),
                 pk(1, 0), 32'd0, 32'd1, 32'd2, 32'd3);
    vecs[3] = mk(32'h1000, 32'h100, pk(0, 0), 2, 0, pk(5, 5), pk(1, 1), 0, 0, 0,
                 32'd1, 32'd0, NONE, NONE);
    vecs[4] = mk(32'h1000, 32'h300, pk(0, 0), 0, 2, 0, 0, 0, 0, 0, NONE, NONE, NONE, NONE);
    vecs[5] = mk(32'h1000, 32'h100, pk(32767, 32767), 2, 0, pk(-32768, -32768), pk(0, 0), 0, 0,
                 0, 32'd1, 32'd0, NONE, NONE);
    vecs[6] = mk(32'hFFFF_FFF8, 32'hFFFF_FFFC, pk(0, 0), 3, 1, pk(2, 0), pk(0, -3), pk(1, 1), 0,
                 0, 32'd2, 32'd0, 32'd1, NONE);
    vecs[7] = mk(32'h4000, 32'h400, pk(0, 0), 5, 2, pk(2, 0), pk(0, 0), pk(0, 2), pk(1, 0),
                 pk(0, -2), 32'd1, 32'd3, 32'd0, 32'd2);

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_valid", 64'(m_valid_o), 64'd0);
    check("rst_addr", m_addr_o, 64'd0);
    check("rst_wdata", m_wdata_o, 64'd0);
    check("rst_wstrb", 64'(m_wstrb_o), 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    for (int v = 0; v < 8; v++) begin
      run(vecs[v], 0, dones);
      check_run(vecs[v], dones);
    end

    // Reset during the third read's wait cycles.
    for (int i = 0; i < 5; i++) mem_pts[i] = vecs[0].pts[i];
    mem_base = vecs[0].base; mem_lat = 3;
    rd_addr.delete(); wr_addr.delete(); wr_data.delete(); wr_strb.delete();
    base_addr_i = vecs[0].base; n_points_i = 16'd5; test_point_i = vecs[0].tp;
    result_addr_i = vecs[0].res; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cyc = 0;
    while (!(rd_addr.size() == 2 && m_valid_o) && cyc < 200) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("third_read_reached", 64'(cyc < 200), 64'd1);
    @(posedge clk_i); #1;
    check("third_read_wait", 64'({m_valid_o, m_ready_i}), 64'b10);
    check("third_read_addr", m_addr_o, 64'h1008);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("midrst_valid", 64'(m_valid_o), 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    @(posedge clk_i); #1;

    // Fresh run after reset, with a start pulsed while busy.
    run(vecs[0], 1, dones);
    check_run(vecs[0], dones);

    // Start in the done cycle is ignored.
    run(vecs[2], 2, dones);
    check_run(vecs[2], dones);
    check("done_start_valid", 64'(m_valid_o), 64'd0);
    @(posedge clk_i); #1;
    check("done_start_busy", 64'(busy_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
